// File: rtl/isa_defs_pkg.sv
// rtl/isa_defs_pkg.sv - ISA field layout, opcodes, extract/pack helpers and loader FSM states
package isa_defs_pkg;

    localparam int OPCODE_W   = 4;
    localparam int REG_ADDR_W = 4;
    localparam int IMM_W      = 16;

    localparam logic [OPCODE_W-1:0] OPC_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OPC_ADD   = 4'h1;
    localparam logic [OPCODE_W-1:0] OPC_SUB   = 4'h2;
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = 4'h3;
    localparam logic [OPCODE_W-1:0] OPC_LOAD  = 4'h4;
    localparam logic [OPCODE_W-1:0] OPC_STORE = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    // Word layout: [31:28] opcode, [27:24] rd / rd_or_rs2, [23:20] rs1,
    // [19:16] rs2 (R-type only), [15:0] imm16 (I-type only).
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [31:0] w);
        return w[31:28];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] get_rtype_rd(input logic [31:0] w);
        return w[27:24];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] get_rtype_rs1(input logic [31:0] w);
        return w[23:20];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] get_rtype_rs2(input logic [31:0] w);
        return w[19:16];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] get_itype_rd_or_rs2(input logic [31:0] w);
        return w[27:24];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] get_itype_rs1(input logic [31:0] w);
        return w[23:20];
    endfunction

    function automatic logic signed [IMM_W-1:0] get_itype_imm(input logic [31:0] w);
        return w[15:0];
    endfunction

    function automatic logic [31:0] pack_rtype(input logic [OPCODE_W-1:0] op,
                                               input logic [REG_ADDR_W-1:0] rd,
                                               input logic [REG_ADDR_W-1:0] rs1,
                                               input logic [REG_ADDR_W-1:0] rs2);
        return {op, rd, rs1, rs2, 16'h0000};
    endfunction

    function automatic logic [31:0] pack_itype(input logic [OPCODE_W-1:0] op,
                                               input logic [REG_ADDR_W-1:0] rd_or_rs2,
                                               input logic [REG_ADDR_W-1:0] rs1,
                                               input logic [IMM_W-1:0] imm16);
        return {op, rd_or_rs2, rs1, 4'h0, imm16};
    endfunction

endpackage

// File: rtl/instr_program_loader_encoder.sv
// rtl/instr_program_loader_encoder.sv - combinational field-set to instruction-word encoder
module instr_encoder
    import isa_defs_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [IMM_W-1:0]      imm16,
    output logic [31:0]           word,
    output logic                  bad_opcode
);

    // Pick the packing by opcode; unknown opcodes collapse to a bare NOP
    always_comb begin
        word       = {OPC_NOP, 28'h0};
        bad_opcode = 1'b0;
        case (opcode)
            OPC_ADD, OPC_SUB:   word = pack_rtype(opcode, rd, rs1, rs2);
            OPC_ADDI, OPC_LOAD: word = pack_itype(opcode, rd, rs1, imm16);
            OPC_STORE:          word = pack_itype(opcode, rs2, rs1, imm16);
            OPC_NOP:            word = {OPC_NOP, 28'h0};
            default:            bad_opcode = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_program_loader.sv
// rtl/instr_program_loader.sv - streams field sets into consecutive instruction-memory words
module instr_program_loader
    import isa_defs_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [OPCODE_W-1:0]   s_opcode,
    input  logic [REG_ADDR_W-1:0] s_rd,
    input  logic [REG_ADDR_W-1:0] s_rs1,
    input  logic [REG_ADDR_W-1:0] s_rs2,
    input  logic [IMM_W-1:0]      s_imm16,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       word_count,
    output logic                  err_overflow,
    output logic                  err_bad_opcode
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_bad_q, err_bad_d;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        full;
    logic        accept;

    instr_encoder u_enc (
        .opcode     (s_opcode),
        .rd         (s_rd),
        .rs1        (s_rs1),
        .rs2        (s_rs2),
        .imm16      (s_imm16),
        .word       (enc_word),
        .bad_opcode (enc_bad)
    );

    // Ready depends only on state and fill level so it never loops through s_valid
    always_comb begin
        full    = (word_count_q >= DEPTH_C);
        s_ready = (state_q == ST_LOAD) && !full;
        accept  = s_valid && s_ready;
    end

    // Next-state, counter and write-port computation
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = 1'b0;
        err_ovf_d    = err_ovf_q;
        err_bad_d    = err_bad_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    word_count_d = '0;
                    err_ovf_d    = 1'b0;
                    err_bad_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d         = 1'b1;
                    addr_d       = word_count_q[ADDR_W-1:0];
                    wdata_d      = enc_word;
                    word_count_d = word_count_q + ONE_C;
                    if (enc_bad) err_bad_d = 1'b1;
                    if (s_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (s_valid && full) begin
                    err_ovf_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_bad_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            err_ovf_q    <= err_ovf_d;
            err_bad_q    <= err_bad_d;
        end
    end

    // Output drive from registers
    always_comb begin
        imem_we        = we_q;
        imem_addr      = addr_q;
        imem_wdata     = wdata_q;
        done           = done_q;
        busy           = (state_q != ST_IDLE);
        word_count     = word_count_q;
        err_overflow   = err_ovf_q;
        err_bad_opcode = err_bad_q;
    end

endmodule
